// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
// MUL_RADIX4_EN selects two multiplier bits per iteration instead of one.
package mul_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0]   word;
  typedef logic [2*XLEN-1:0] dword;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_t;

`ifdef MUL_RADIX4_EN
  localparam int unsigned MUL_BITS_PER_STEP = 2;
`else
  localparam int unsigned MUL_BITS_PER_STEP = 1;
`endif

  localparam int unsigned MUL_STEPS = XLEN / MUL_BITS_PER_STEP;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_STEPS);

  // Absolute value of a 32-bit operand; 0x80000000 maps onto itself, which is its unsigned magnitude.
  function automatic word mag(input word v, input logic is_neg);
    return is_neg ? word'(-v) : v;
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Core-to-multiplier handshake: operands and op in, stall/done/result out.
interface mul_unit_if;
  import mul_unit_pkg::*;

  logic    start;
  word     a;
  word     b;
  mul_op_t mul_op;
  logic    stall;
  logic    done;
  word     result;

  modport master (
    output start, a, b, mul_op,
    input  stall, done, result
  );

  modport slave (
    input  start, a, b, mul_op,
    output stall, done, result
  );

endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: adds the selected partial product into the accumulator.
// MUL_RADIX4_EN selects a 0/1x/2x/3x multiplicand per two multiplier bits.
module mul_step
  import mul_unit_pkg::*;
(
  input  dword                         acc_i,
  input  dword                         mcand_i,
`ifdef MUL_RADIX4_EN
  input  dword                         mcand3_i,
`endif
  input  logic [MUL_BITS_PER_STEP-1:0] bits_i,
  output dword                         acc_o
);

  dword pp;

  always_comb begin
    pp = '0;
`ifdef MUL_RADIX4_EN
    unique case (bits_i)
      2'd0: pp = '0;
      2'd1: pp = mcand_i;
      2'd2: pp = mcand_i << 1;
      2'd3: pp = mcand3_i;
    endcase
`else
    pp = bits_i[0] ? mcand_i : '0;
`endif
  end

  assign acc_o = acc_i + pp;

endmodule

// File: rtl/mul_unit.sv
// Iterative sign-magnitude shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// MUL_RADIX4_EN halves the iteration count; results are identical in both builds.
module mul_unit
  import mul_unit_pkg::*;
(
  input logic       clk,
  input logic       reset,
  mul_unit_if.slave bus
);

  localparam int unsigned STEPS = MUL_STEPS;

  mul_state_t           state_q;
  mul_op_t              op_q;
  logic                 neg_q;
  dword                 acc_q;
  dword                 acc_d;
  dword                 mcand_q;
  word                  mplier_q;
  logic [MUL_CNT_W-1:0] cnt_q;
  logic                 done_q;
  word                  result_q;
`ifdef MUL_RADIX4_EN
  dword                 mcand3_q;
`endif

  logic a_signed;
  logic b_signed;
  logic neg_a;
  logic neg_b;
  word  mag_a;
  word  mag_b;
  dword prod;

  // Operand sign handling at acceptance; MUL's low half is sign-agnostic.
  assign a_signed = (bus.mul_op == MULH) || (bus.mul_op == MULHSU);
  assign b_signed = (bus.mul_op == MULH);
  assign neg_a    = a_signed && bus.a[XLEN-1];
  assign neg_b    = b_signed && bus.b[XLEN-1];
  assign mag_a    = mag(bus.a, neg_a);
  assign mag_b    = mag(bus.b, neg_b);

  assign prod = neg_q ? dword'(-acc_q) : acc_q;

  mul_step u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
`ifdef MUL_RADIX4_EN
    .mcand3_i (mcand3_q),
`endif
    .bits_i   (mplier_q[MUL_BITS_PER_STEP-1:0]),
    .acc_o    (acc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.mul_op;
            neg_q    <= neg_a ^ neg_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= dword'(mag_a);
            mplier_q <= mag_b;
`ifdef MUL_RADIX4_EN
            mcand3_q <= (dword'(mag_a) << 1) + dword'(mag_a);
`endif
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Multiplicand walks left while the multiplier walks right past the low bits.
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << MUL_BITS_PER_STEP;
          mplier_q <= mplier_q >> MUL_BITS_PER_STEP;
`ifdef MUL_RADIX4_EN
          mcand3_q <= mcand3_q << MUL_BITS_PER_STEP;
`endif
          cnt_q    <= cnt_q + MUL_CNT_W'(1);
          if (cnt_q == MUL_CNT_W'(STEPS - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall  = ((state_q == IDLE) && bus.start) || (state_q == RUN) || (state_q == FIX);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_mul_unit;
  import mul_unit_pkg::*;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mul_unit_if bus ();

  mul_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: sign- or zero-extend to 64 bits and take the wrapped product.
  function automatic word ref_mul(input mul_op_t op, input word a, input word b);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = (op == MULH || op == MULHSU) ? longint'($signed(a)) : longint'(a);
    sb = (op == MULH) ? longint'($signed(b)) : longint'(b);
    p  = 64'(sa * sb);
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic word pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return word'($urandom);
    endcase
  endfunction

  // Issue one multiply from IDLE, scramble inputs after acceptance, check latency, stall and result.
  task automatic do_mul(input string tag, input mul_op_t op, input word a, input word b, input word exp);
    int   cyc;
    logic stall_ok;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mul_op = op;
    bus.a      = a;
    bus.b      = b;
    #1;
    stall_ok = bus.stall && !bus.done;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a      = word'($urandom);
    bus.b      = word'($urandom);
    bus.mul_op = mul_op_t'($urandom_range(0, 3));
    cyc = 1;
    while (!bus.done && cyc < 3 * LAT) begin
      if (!bus.stall) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(LAT));
    chk({tag, "_stall"}, 32'({stall_ok, bus.stall}), 32'(2'b10));
    chk({tag, "_res"}, bus.result, exp);
  endtask

  initial begin
    int   n_done;
    int   first_done;
    int   second_done;
    int   done_seen;
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.mul_op = MUL;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'h0);

    do_mul("mul_7", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_mul("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_mul("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_mul("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_mul("mul_max", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    do_mul("mul_zero", MUL, 32'h0, 32'h1234_5678, 32'h0);

    // Reset during RUN cycle 10 aborts the multiply and clears result.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mul_op = MULHU;
    bus.a      = 32'hDEAD_BEEF;
    bus.b      = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstrun_stall", 32'(bus.stall), 32'd0);
    chk("rstrun_done", 32'(bus.done), 32'd0);
    chk("rstrun_result", bus.result, 32'h0);
    done_seen = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("rstrun_nodone", 32'(done_seen), 32'd0);
    do_mul("mulhu_2x3", MULHU, 32'd2, 32'd3, 32'h0);
    do_mul("mul_2x3", MUL, 32'd2, 32'd3, 32'd6);

    // start held through DONE, a changed mid-RUN: second accept only after DONE.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mul_op  = MUL;
    bus.a       = 32'd5;
    bus.b       = 32'd7;
    n_done      = 0;
    first_done  = 0;
    second_done = 0;
    for (int c = 1; c <= 2 * LAT + 1; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = c;
          chk("held_res1", bus.result, 32'd35);
        end else if (n_done == 2) begin
          second_done = c;
          chk("held_res2", bus.result, 32'h0006_FFF9);
        end
      end
      if (c == LAT) chk("held_stall_in_done", 32'(bus.stall), 32'd0);
      if (c == LAT + 1) chk("held_stall_reaccept", 32'(bus.stall), 32'd1);
      if (c == 5) bus.a = 32'h0000_FFFF;
    end
    bus.start = 1'b0;
    chk("held_ndone", 32'(n_done), 32'd2);
    chk("held_first", 32'(first_done), 32'(LAT));
    chk("held_second", 32'(second_done), 32'(2 * LAT + 1));

    // Random operations, with boundary operands mixed in.
    for (int i = 0; i < 40; i++) begin
      mul_op_t op;
      word     ra;
      word     rb;
      op = mul_op_t'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      do_mul($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, ref_mul(op, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
